// File: rtl/if_prefetch_unit_pkg.sv
// Shared constants and PC helper for the instruction-fetch prefetch unit.
package if_prefetch_unit_pkg;

    localparam int INSTR_W    = 32;
    localparam int WORD_BYTES = 4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    // Sequential word address; wraps modulo 2^32.
    function automatic logic [31:0] next_word(input logic [31:0] pc);
        return pc + 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// Prefetch FIFO holding {instruction, PC} pairs; head is read straight from storage.
module prefetch_fifo
    import if_prefetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [INSTR_W-1:0]       push_instr,
    input  logic [31:0]              push_pc,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [INSTR_W-1:0]       head_instr,
    output logic [31:0]              head_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [31:0]        pc_mem    [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign do_pop  = pop && (count != '0) && !flush;
    assign do_push = push && !flush && ((count < FULL_CNT) || do_pop);

    assign head_instr = instr_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            instr_mem[wr_ptr] <= push_instr;
            pc_mem[wr_ptr]    <= push_pc;
        end
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch front end: one outstanding imem request, prefetch FIFO, stall and redirect handling.
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]        fetch_pc;
    logic [31:0]        resume_pc;
    logic [31:0]        head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_next;
    logic               drop;
    logic               ack_hit;
    logic               push;
    logic               pop;
    logic               issue_ok;

    assign ack_hit    = imem_req && imem_ack;
    assign push       = ack_hit && !drop && !redirect;
    assign if_valid   = (count != '0);
    assign pop        = if_valid && !stall && !redirect;
    assign count_next = count + CW'(push) - CW'(pop);
    // Issuing against the post-edge count guarantees room when the single in-flight word lands.
    assign issue_ok   = (count_next < FULL_CNT);
    assign resume_pc  = drop ? fetch_pc : next_word(imem_addr);

    assign if_instr    = if_valid ? head_instr : NOP_INSTR;
    assign if_pc_plus4 = if_valid ? next_word(head_pc) : 32'h0;

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_instr (imem_rdata),
        .push_pc    (imem_addr),
        .pop        (pop),
        .count      (count),
        .head_instr (head_instr),
        .head_pc    (head_pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            drop      <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            // An unacked request must stay on the bus; its data is discarded on arrival.
            if (imem_req && !imem_ack) begin
                drop <= 1'b1;
            end else begin
                imem_req <= 1'b0;
                drop     <= 1'b0;
            end
        end else if (ack_hit) begin
            drop     <= 1'b0;
            fetch_pc <= resume_pc;
            imem_req <= issue_ok;
            if (issue_ok) imem_addr <= resume_pc;
        end else if (!imem_req && issue_ok) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: vector table plus hand-written redirect/reset/wrap sequences.
module tb_if_prefetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        zw;
    logic        man_ack;

    logic        rst_w;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_stall;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_0000;
    endfunction

    assign imem_ack   = zw ? imem_req : man_ack;
    assign imem_rdata = instr_of(imem_addr);
    assign w_rdata    = instr_of(w_addr);

    if_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc_plus4(if_pc_plus4)
    );

    if_prefetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst_w), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_req), .imem_rdata(w_rdata), .stall(w_stall),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc), .if_valid(w_valid),
        .if_instr(w_instr), .if_pc_plus4(w_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        exp_valid;
        logic [31:0] exp_pc4;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic r, input logic s, input logic v,
                           input logic [31:0] p, input logic q, input logic [31:0] a);
        vec_t t;
        t.rst_n = r; t.stall = s; t.exp_valid = v; t.exp_pc4 = p; t.exp_req = q; t.exp_addr = a;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag,
                           input logic a_v, input logic [31:0] a_i, input logic [31:0] a_p,
                           input logic a_q, input logic [31:0] a_a,
                           input logic e_v, input logic [31:0] e_p,
                           input logic e_q, input logic [31:0] e_a);
        logic [31:0] e_i;
        e_i = e_v ? instr_of(e_p - 32'd4) : 32'h0;
        chk({tag, ".if_valid"},    {31'b0, a_v}, {31'b0, e_v});
        chk({tag, ".if_pc_plus4"}, a_p, e_p);
        chk({tag, ".if_instr"},    a_i, e_i);
        chk({tag, ".imem_req"},    {31'b0, a_q}, {31'b0, e_q});
        chk({tag, ".imem_addr"},   a_a, e_a);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dut(input string tag, input logic v, input logic [31:0] p,
                           input logic q, input logic [31:0] a);
        chk_out(tag, if_valid, if_instr, if_pc_plus4, imem_req, imem_addr, v, p, q, a);
    endtask

    task automatic chk_w(input string tag, input logic v, input logic [31:0] p,
                         input logic q, input logic [31:0] a);
        chk_out(tag, w_valid, w_instr, w_pc4, w_req, w_addr, v, p, q, a);
    endtask

    task automatic do_reset();
        rst = 1'b0; zw = 1'b0; man_ack = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; zw = 1'b1; man_ack = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        rst_w = 1'b0; w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = 32'h0;

        // Zero-wait streaming, then reset and a 10-cycle stall that fills the FIFO and drains it.
        add_vec(1, 0, 0, 32'h00, 1, 32'h00);
        add_vec(1, 0, 1, 32'h04, 1, 32'h04);
        add_vec(1, 0, 1, 32'h08, 1, 32'h08);
        add_vec(1, 0, 1, 32'h0C, 1, 32'h0C);
        add_vec(0, 1, 0, 32'h00, 0, 32'h00);
        add_vec(1, 1, 0, 32'h00, 1, 32'h00);
        add_vec(1, 1, 1, 32'h04, 1, 32'h04);
        add_vec(1, 1, 1, 32'h04, 1, 32'h08);
        add_vec(1, 1, 1, 32'h04, 1, 32'h0C);
        add_vec(1, 1, 1, 32'h04, 0, 32'h0C);
        for (int i = 0; i < 5; i++) add_vec(1, 1, 1, 32'h04, 0, 32'h0C);
        add_vec(1, 0, 1, 32'h08, 1, 32'h10);
        add_vec(1, 0, 1, 32'h0C, 1, 32'h14);
        add_vec(1, 0, 1, 32'h10, 1, 32'h18);
        add_vec(1, 0, 1, 32'h14, 1, 32'h1C);

        repeat (2) cyc();
        chk_dut("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        chk_dut("release", 1'b0, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            rst   = vq[i].rst_n;
            stall = vq[i].stall;
            cyc();
            chk_dut($sformatf("vec%0d", i), vq[i].exp_valid, vq[i].exp_pc4,
                    vq[i].exp_req, vq[i].exp_addr);
        end

        // Redirect to 0x40 while 0x10 is outstanding; ack arrives three cycles later.
        do_reset();
        zw = 1'b1;
        repeat (5) cyc();
        zw = 1'b0;
        chk_dut("rd_pre", 1'b1, 32'h10, 1'b1, 32'h10);
        redirect = 1'b1; redirect_pc = 32'h40;
        cyc();
        redirect = 1'b0;
        chk_dut("rd_flush", 1'b0, 32'h0, 1'b1, 32'h10);
        cyc();
        chk_dut("rd_hold1", 1'b0, 32'h0, 1'b1, 32'h10);
        cyc();
        chk_dut("rd_hold2", 1'b0, 32'h0, 1'b1, 32'h10);
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        chk_dut("rd_drop", 1'b0, 32'h0, 1'b1, 32'h40);
        zw = 1'b1;
        cyc();
        chk_dut("rd_first", 1'b1, 32'h44, 1'b1, 32'h44);

        // Redirect to 0x43 coincident with ack and stall.
        do_reset();
        cyc();
        chk_dut("ra_req", 1'b0, 32'h0, 1'b1, 32'h0);
        man_ack = 1'b1;
        cyc();
        chk_dut("ra_push", 1'b1, 32'h4, 1'b1, 32'h4);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h43;
        cyc();
        redirect = 1'b0; man_ack = 1'b0;
        chk_dut("ra_flush", 1'b0, 32'h0, 1'b0, 32'h4);
        cyc();
        chk_dut("ra_issue", 1'b0, 32'h0, 1'b1, 32'h40);
        zw = 1'b1; stall = 1'b0;
        cyc();
        chk_dut("ra_first", 1'b1, 32'h44, 1'b1, 32'h44);

        // Reset mid-request, stray ack during and after reset.
        do_reset();
        cyc();
        chk_dut("rs_req", 1'b0, 32'h0, 1'b1, 32'h0);
        man_ack = 1'b1;
        rst = 1'b0;
        #1;
        chk_dut("rs_async", 1'b0, 32'h0, 1'b0, 32'h0);
        cyc();
        rst = 1'b1;
        cyc();
        man_ack = 1'b0;
        chk_dut("rs_stray", 1'b0, 32'h0, 1'b1, 32'h0);
        cyc();
        chk_dut("rs_wait", 1'b0, 32'h0, 1'b1, 32'h0);
        zw = 1'b1;
        cyc();
        chk_dut("rs_restart", 1'b1, 32'h4, 1'b1, 32'h4);

        // PC wrap at the top of the address space.
        chk_w("wr_reset", 1'b0, 32'h0, 1'b0, 32'hFFFF_FFF8);
        rst_w = 1'b1;
        cyc();
        chk_w("wr_c1", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        cyc();
        chk_w("wr_c2", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
        cyc();
        chk_w("wr_c3", 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000);
        cyc();
        chk_w("wr_c4", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
